// File: rtl/rv_pipe_pkg.sv
// Shared widths and result-entry layout for the rv32im_zbb in-flight result pipeline.
// Entry layout, MSB first: {valid, we, pend, rd[AW], data[XLEN]}.
package rv_pipe_pkg;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned AW       = 5;
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned RD_LSB   = XLEN;
  localparam int unsigned PEND_BIT = XLEN + AW;
  localparam int unsigned WE_BIT   = XLEN + AW + 1;
  localparam int unsigned VLD_BIT  = XLEN + AW + 2;
  localparam int unsigned ENT_W    = 3 + AW + XLEN;

  function automatic int unsigned ent_w(input int unsigned xlen, input int unsigned aw);
    return 3 + aw + xlen;
  endfunction
endpackage

// File: rtl/fwd_pipe_stage.sv
// One in-flight result entry: load, hold, bubble or flush, with optional load-data fill on load.
module fwd_pipe_stage
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN = rv_pipe_pkg::XLEN,
  parameter int unsigned AW   = rv_pipe_pkg::AW,
  parameter bit          FILL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   bubble,
  input  logic                   flush,
  input  logic [XLEN+AW+2:0]     d,
  input  logic [XLEN-1:0]        fill_data,
  output logic [XLEN+AW+2:0]     q
);
  localparam int unsigned PEND = XLEN + AW;
  localparam int unsigned VLD  = XLEN + AW + 2;

  logic [XLEN+AW+2:0] nxt;

  always_comb begin
    nxt = d;
    if (FILL && d[PEND]) begin
      nxt[PEND]       = 1'b0;
      nxt[XLEN-1:0]   = fill_data;
    end
  end

  // Flush outranks load/hold; only valid is cleared, the other fields are don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q      <= '0;
    else if (flush)  q[VLD] <= 1'b0;
    else if (load)   q      <= nxt;
    else if (bubble) q[VLD] <= 1'b0;
  end
endmodule

// File: rtl/fwd_pipe_chain.sv
// DEPTH-stage result pipeline with per-stage hold/flush, load fill and priority operand forwarding.
module fwd_pipe_chain
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = rv_pipe_pkg::XLEN,
  parameter int unsigned AW         = rv_pipe_pkg::AW,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FILL_STAGE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  input  logic                    in_we_i,
  input  logic                    in_pend_i,
  input  logic [AW-1:0]           in_rd_i,
  input  logic [XLEN-1:0]         in_data_i,
  output logic                    in_ready_o,
  input  logic [DEPTH-1:0]        hold_i,
  input  logic [DEPTH-1:0]        flush_i,
  input  logic [XLEN-1:0]         fill_data_i,
  input  logic [NUM_SRC*AW-1:0]   src_addr_i,
  input  logic [NUM_SRC*XLEN-1:0] src_rf_data_i,
  output logic [NUM_SRC*XLEN-1:0] src_data_o,
  output logic [NUM_SRC-1:0]      src_hit_o,
  output logic [NUM_SRC-1:0]      src_wait_o,
  output logic                    wb_we_o,
  output logic [AW-1:0]           wb_rd_o,
  output logic [XLEN-1:0]         wb_data_o
);
  localparam int unsigned EW   = ent_w(XLEN, AW);
  localparam int unsigned IW   = $clog2(DEPTH);
  localparam int unsigned RD   = XLEN;
  localparam int unsigned PEND = XLEN + AW;
  localparam int unsigned WE   = XLEN + AW + 1;
  localparam int unsigned VLD  = XLEN + AW + 2;

  logic [DEPTH-1:0] stall;
  logic [EW-1:0]    ent [DEPTH];
  logic [EW-1:0]    in_ent;

  assign in_ent     = {in_valid_i, in_we_i, in_pend_i, in_rd_i, in_data_i};
  assign in_ready_o = ~stall[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stall
    assign stall[k] = |hold_i[DEPTH-1:k];
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          load, bubble;
    logic [EW-1:0] d;
    if (k == 0) begin : g_head
      assign d      = in_ent;
      assign load   = ~stall[0];
      assign bubble = 1'b0;
    end else begin : g_body
      // A held predecessor with a free successor leaves a bubble behind it.
      assign d      = ent[k-1];
      assign load   = ~stall[k] & ~stall[k-1];
      assign bubble = ~stall[k] & stall[k-1];
    end

    fwd_pipe_stage #(
      .XLEN (XLEN),
      .AW   (AW),
      .FILL (k == FILL_STAGE)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .bubble    (bubble),
      .flush     (flush_i[k]),
      .d         (d),
      .fill_data (fill_data_i),
      .q         (ent[k])
    );
  end

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_fwd
    logic [XLEN-1:0] fdata;
    logic            fhit, fwait;

    // Scan oldest to youngest so the lowest-index match is the one left standing.
    always_comb begin
      fdata = src_rf_data_i[p*XLEN +: XLEN];
      fhit  = 1'b0;
      fwait = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        int unsigned s;
        s = DEPTH - 1 - j;
        if (ent[IW'(s)][VLD] && ent[IW'(s)][WE] &&
            ent[IW'(s)][RD +: AW] == src_addr_i[p*AW +: AW] &&
            src_addr_i[p*AW +: AW] != '0) begin
          fhit  = 1'b1;
          fdata = ent[IW'(s)][XLEN-1:0];
          fwait = ent[IW'(s)][PEND];
        end
      end
    end

    assign src_data_o[p*XLEN +: XLEN] = fdata;
    assign src_hit_o[p]               = fhit;
    assign src_wait_o[p]              = fwait;
  end

  assign wb_we_o   = ent[DEPTH-1][VLD] & ent[DEPTH-1][WE] & ~hold_i[DEPTH-1];
  assign wb_rd_o   = ent[DEPTH-1][RD +: AW];
  assign wb_data_o = ent[DEPTH-1][XLEN-1:0];
endmodule

// File: tb/tb_fwd_pipe_chain.sv
// Directed bench for fwd_pipe_chain (DEPTH=3, two ports, fill at stage 1) with a writeback scoreboard.
module tb_fwd_pipe_chain;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned NSRC = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   in_valid_i = 1'b0, in_we_i = 1'b0, in_pend_i = 1'b0;
  logic [AW-1:0]          in_rd_i = '0;
  logic [XLEN-1:0]        in_data_i = '0;
  logic                   in_ready_o;
  logic [DEPTH-1:0]       hold_i = '0, flush_i = '0;
  logic [XLEN-1:0]        fill_data_i = '0;
  logic [NSRC*AW-1:0]     src_addr_i = '0;
  logic [NSRC*XLEN-1:0]   src_rf_data_i = '0;
  logic [NSRC*XLEN-1:0]   src_data_o;
  logic [NSRC-1:0]        src_hit_o, src_wait_o;
  logic                   wb_we_o;
  logic [AW-1:0]          wb_rd_o;
  logic [XLEN-1:0]        wb_data_o;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [AW-1:0] rd; logic [XLEN-1:0] data; } wb_t;
  wb_t sb[$];

  always #5 clk = ~clk;

  fwd_pipe_chain #(
    .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .NUM_SRC(NSRC), .FILL_STAGE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_we_i(in_we_i), .in_pend_i(in_pend_i),
    .in_rd_i(in_rd_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .hold_i(hold_i), .flush_i(flush_i), .fill_data_i(fill_data_i),
    .src_addr_i(src_addr_i), .src_rf_data_i(src_rf_data_i),
    .src_data_o(src_data_o), .src_hit_o(src_hit_o), .src_wait_o(src_wait_o),
    .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic pend,
                       input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    in_valid_i = v; in_we_i = we; in_pend_i = pend; in_rd_i = rd; in_data_i = data;
  endtask

  task automatic push(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    wb_t e;
    e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  // Every observed write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!rst && wb_we_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL wb_unexpected: observed rd=0x%0h data=0x%0h expected no write", wb_rd_o, wb_data_o);
      end else begin
        wb_t e;
        e = sb.pop_front();
        chk("wb_rd", 64'(wb_rd_o), 64'(e.rd));
        chk("wb_data", 64'(wb_data_o), 64'(e.data));
      end
    end
  end

  initial begin
    src_rf_data_i = {32'h5678_0000, 32'h1234_0000};
    src_addr_i    = {5'd0, 5'd5};
    #1 rst = 1'b1;
    #1;
    chk("rst_wb_we", 64'(wb_we_o), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd_o), 64'd0);
    chk("rst_wb_data", 64'(wb_data_o), 64'd0);
    chk("rst_hit", 64'(src_hit_o), 64'd0);
    chk("rst_wait", 64'(src_wait_o), 64'd0);
    chk("rst_src_data", 64'(src_data_o), 64'h5678_0000_1234_0000);
    chk("rst_ready", 64'(in_ready_o), 64'd1);
    step(); step();
    rst = 1'b0;

    // Stream two entries back to back
    drive(1, 1, 0, 5'd5, 32'h11); push(5'd5, 32'h11);
    step();
    drive(1, 1, 0, 5'd6, 32'h22); push(5'd6, 32'h22);
    step();
    drive(0, 0, 0, 5'd0, 32'h0);
    chk("stream_lat_early", 64'(wb_we_o), 64'd0);
    step();
    chk("stream_we_a", 64'(wb_we_o), 64'd1);
    chk("stream_rd_a", 64'(wb_rd_o), 64'd5);
    step();
    chk("stream_we_b", 64'(wb_we_o), 64'd1);
    chk("stream_rd_b", 64'(wb_rd_o), 64'd6);
    step();
    chk("stream_idle", 64'(wb_we_o), 64'd0);

    // Priority: youngest match wins, address 0 never hits
    drive(1, 1, 0, 5'd7, 32'hB); push(5'd7, 32'hB);
    step();
    drive(1, 1, 0, 5'd7, 32'hA); push(5'd7, 32'hA);
    step();
    drive(0, 0, 0, 5'd0, 32'h0);
    src_addr_i = {5'd0, 5'd7};
    #1;
    chk("prio_data", 64'(src_data_o[31:0]), 64'hA);
    chk("prio_hit", 64'(src_hit_o[0]), 64'd1);
    chk("zero_hit", 64'(src_hit_o[1]), 64'd0);
    chk("zero_data", 64'(src_data_o[63:32]), 64'h5678_0000);
    step(); step(); step();

    // Non-writing entry never forwards and never writes back
    drive(1, 0, 0, 5'd3, 32'h33);
    step();
    drive(0, 0, 0, 5'd0, 32'h0);
    src_addr_i = {5'd0, 5'd3};
    #1;
    chk("nowe_hit", 64'(src_hit_o[0]), 64'd0);
    step(); step(); step();

    // Load: pending in stage 0, filled on entry to stage 1
    drive(1, 1, 1, 5'd9, 32'hBAD); push(5'd9, 32'hDEAD);
    step();
    drive(0, 0, 0, 5'd0, 32'h0);
    src_addr_i  = {5'd0, 5'd9};
    fill_data_i = 32'hDEAD;
    #1;
    chk("load_wait", 64'(src_wait_o[0]), 64'd1);
    chk("load_hit", 64'(src_hit_o[0]), 64'd1);
    step();
    fill_data_i = 32'h0;
    chk("fill_wait", 64'(src_wait_o[0]), 64'd0);
    chk("fill_data", 64'(src_data_o[31:0]), 64'hDEAD);
    step(); step();

    // Hold stage 1 for two edges
    drive(1, 1, 0, 5'd10, 32'h10); push(5'd10, 32'h10);
    step();
    drive(1, 1, 0, 5'd11, 32'h11); push(5'd11, 32'h11);
    step();
    drive(0, 0, 0, 5'd0, 32'h0);
    hold_i = 3'b010;
    src_addr_i = {5'd10, 5'd11};
    #1;
    chk("hold_ready", 64'(in_ready_o), 64'd0);
    step();
    chk("hold_bubble_we", 64'(wb_we_o), 64'd0);
    chk("hold_s0_data", 64'(src_data_o[31:0]), 64'h11);
    chk("hold_s1_data", 64'(src_data_o[63:32]), 64'h10);
    step();
    chk("hold_ready2", 64'(in_ready_o), 64'd0);
    chk("hold_bubble_we2", 64'(wb_we_o), 64'd0);
    hold_i = 3'b000;
    step();
    chk("drain_we", 64'(wb_we_o), 64'd1);
    chk("drain_rd", 64'(wb_rd_o), 64'd10);
    step();
    chk("drain_rd2", 64'(wb_rd_o), 64'd11);
    step();

    // Flush beats hold on the writeback stage
    drive(1, 1, 0, 5'd12, 32'h12);
    step();
    drive(0, 0, 0, 5'd0, 32'h0);
    step(); step();
    hold_i = 3'b100; flush_i = 3'b100;
    src_addr_i = {5'd0, 5'd12};
    #1;
    chk("flush_gate_we", 64'(wb_we_o), 64'd0);
    chk("flush_pre_hit", 64'(src_hit_o[0]), 64'd1);
    step();
    hold_i = 3'b000; flush_i = 3'b000;
    #1;
    chk("flush_gone_we", 64'(wb_we_o), 64'd0);
    chk("flush_gone_hit", 64'(src_hit_o[0]), 64'd0);
    step();

    // Asynchronous reset between edges drops in-flight entries
    drive(1, 1, 0, 5'd13, 32'h13);
    step();
    drive(1, 1, 0, 5'd14, 32'h14);
    step();
    drive(0, 0, 0, 5'd0, 32'h0);
    src_addr_i = {5'd0, 5'd14};
    step();
    chk("pre_rst_we", 64'(wb_we_o), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_we", 64'(wb_we_o), 64'd0);
    chk("async_rst_hit", 64'(src_hit_o), 64'd0);
    step();
    rst = 1'b0;
    drive(1, 1, 0, 5'd15, 32'h15); push(5'd15, 32'h15);
    step();
    drive(0, 0, 0, 5'd0, 32'h0);
    step(); step();
    chk("resume_we", 64'(wb_we_o), 64'd1);
    chk("resume_rd", 64'(wb_rd_o), 64'd15);
    step(); step();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fwd_pipe_chain.md
# fwd_pipe_chain

Parametrised in-flight result pipeline for the rv32im_zbb core. It replaces the hand-built EX/MEM and MEM/WB result registers with a DEPTH-stage chain of {valid, we, pend, rd, data} entries. Each stage has its own hold and flush. The block provides NUM_SRC operand forwarding ports that return the youngest matching in-flight value, or a wait flag when that value is a load not yet filled. It sits between the ALU output and the register-file write port.

## Interface
- XLEN, 32, data width.
- AW, 5, register address width.
- DEPTH, 3, number of stages (≥2); stage 0 is youngest, stage DEPTH-1 is writeback.
- NUM_SRC, 2, forwarding ports (≥1).
- FILL_STAGE, 1, stage whose input transfer merges load data (1..DEPTH-1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  new result offered to stage 0.
- in_we_i  in  1  entry writes the register file.
- in_pend_i  in  1  data not yet available (load); filled at FILL_STAGE.
- in_rd_i  in  AW  destination register.
- in_data_i  in  XLEN  result data (don't-care if pend).
- in_ready_o  out  1  stage 0 accepts this cycle.
- hold_i  in  DEPTH  per-stage hold request.
- flush_i  in  DEPTH  per-stage flush.
- fill_data_i  in  XLEN  load data merged on transfer into FILL_STAGE.
- src_addr_i  in  NUM_SRC*AW  operand addresses, port k at [k*AW +: AW].
- src_rf_data_i  in  NUM_SRC*XLEN  register-file read data per port.
- src_data_o  out  NUM_SRC*XLEN  forwarded operand.
- src_hit_o  out  NUM_SRC  an in-flight entry matched.
- src_wait_o  out  NUM_SRC  youngest match still pending.
- wb_we_o  out  1  register-file write strobe.
- wb_rd_o  out  AW  write address.
- wb_data_o  out  XLEN  write data.

## Operation
- Effective stall: stall[DEPTH-1] = hold_i[DEPTH-1]; stall[k] = hold_i[k] | stall[k+1]. An older stall freezes all younger stages.
- in_ready_o = ~stall[0]. Stage 0 loads {in_valid_i, in_we_i, in_pend_i, in_rd_i, in_data_i} when not stalled.
- Stage k>0 when not stalled: loads stage k-1 contents if stall[k-1]=0. If stall[k-1]=1 (only possible when hold_i[k-1] is set), it loads a bubble (valid=0).
- A stalled stage keeps its contents.
- Flush: flush_i[k] sets valid[k]=0 at the edge. It overrides hold and load. Other fields are don't-care.
- Fill: on a transfer into FILL_STAGE, if the source entry has pend=1, then data ← fill_data_i and pend ← 0. Non-pending entries pass unchanged.
- Stages ≥ FILL_STAGE always have pend=0.
- Forwarding, per port, combinational:
  - Candidate stage j: valid & we & rd==src_addr & src_addr≠0.
  - The lowest-index candidate wins.
  - Hit: src_hit=1, src_data = winner data, src_wait = winner pend.
  - No candidate: src_hit=0, src_wait=0, src_data = src_rf_data_i.
  - Address 0 never hits.
- Writeback: wb_we_o = valid & we of stage DEPTH-1, gated by ~hold_i[DEPTH-1]. wb_rd_o and wb_data_o show stage DEPTH-1 contents.
- The entry in stage DEPTH-1 retires when it is not held.
- Entries with we=0 or rd=0 flow through normally but never forward.

## Timing
- Reset (async) clears all stages: valid=0, we=0, pend=0, rd=0, data=0.
- Output values in reset: wb_we_o=0, wb_rd_o=0, wb_data_o=0, src_hit_o=0, src_wait_o=0, src_data_o=src_rf_data_i, in_ready_o=~hold_i[0..]-derived.
- Latency: an accepted entry reaches stage DEPTH-1 DEPTH-1 edges after acceptance, so wb_we_o is asserted in cycle DEPTH-1 after the accept cycle. Total input→write is DEPTH cycles with no stalls.
- Forwarding has zero cycle latency: all src_* outputs follow stage registers and inputs combinationally.
- Flush and hold on the same stage in the same cycle: flush wins, stage is empty next cycle.
- Flush of stage k with hold on k-1: stage k is empty next cycle; the held entry stays in k-1.
- Reset asserted mid-stream drops all entries immediately. No writeback occurs during reset.

## Structure
- Shared package rv_pipe_pkg (Verilog header of localparams): XLEN, AW, and the entry field offsets VLD/WE/PEND/RD/DATA, giving entry width 3+AW+XLEN.
- Sub-module fwd_pipe_stage: one entry register with async reset, load/hold/bubble/flush select, and an optional fill merge (FILL parameter). It is instantiated DEPTH times in a generate loop.
- The priority forwarding mux lives in the top module, one generate instance per port.

## Test plan
- Stream: accept rd=5 data=0x11 and rd=6 data=0x22 on consecutive cycles, no hold → wb_we_o pulses in cycles 2 and 3 with matching rd and data (DEPTH=3).
- Priority: stage0 rd=7 data=0xA, stage1 rd=7 data=0xB, src_addr=7 → src_data=0xA, hit=1. With src_addr=0 → src_data=rf data, hit=0.
- Load: accept rd=9 pend=1 → src_wait=1 for port addr 9. Next edge, with fill_data_i=0xDEAD, the entry enters stage 1 → src_wait=0, src_data=0xDEAD.
- Hold: hold_i[1]=1 for 2 cycles with entries in stages 0 and 1 → both frozen, in_ready_o=0, stage 2 receives a bubble and no write happens. Release → normal drain.
- Flush vs hold: hold_i[2]=1 and flush_i[2]=1 on valid stage 2 → wb_we_o=0 next cycle and the entry is gone.
- Async reset: assert rst mid-stream between edges → wb_we_o=0 and src_hit_o=0 immediately. Streaming resumes normally after deassert.
